// File: rtl/seq_adder32_pkg.sv
// seq_adder32_pkg
//   Shared definitions for the chunked sequential adder:
//   - state_e   : controller states (idle / running chunks / result held)
//   - CHUNK_W   : width of one adder chunk
//   - idx_width : width of the chunk index counter for a given chunk count
package seq_adder32_pkg;

  localparam int CHUNK_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int idx_width(input int n_chunks);
    return $clog2(n_chunks);
  endfunction

endpackage

// File: rtl/seq_adder32_cla16.sv
// CLAAdder16
//   16-bit two-level carry-lookahead adder: four 4-bit lookahead groups with
//   a second lookahead level across the group propagate/generate terms.
// Ports:
//   a, b  : 16-bit operands
//   cin   : carry in
//   sum   : 16-bit sum
//   cout  : carry out of bit 15
//   p, g  : block propagate / generate over all 16 bits
module CLAAdder16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout,
  output logic        p,
  output logic        g
);

  logic [15:0] bp;
  logic [15:0] bg;
  logic [3:0]  gp;
  logic [3:0]  gg;
  logic [4:0]  gc;
  logic        c_run;

  // Bit and group propagate/generate, then group carries in flat lookahead form.
  always_comb begin
    bp = a ^ b;
    bg = a & b;
    gp = '0;
    gg = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      gp[k] = &bp[4*k +: 4];
      gg[k] = bg[4*k+3]
            | (bp[4*k+3] & bg[4*k+2])
            | (bp[4*k+3] & bp[4*k+2] & bg[4*k+1])
            | (bp[4*k+3] & bp[4*k+2] & bp[4*k+1] & bg[4*k]);
    end
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & cin);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
  end

  // Within a group the carry only spans 4 bits from the lookahead group carry.
  always_comb begin
    sum   = '0;
    c_run = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      c_run = gc[k];
      for (int unsigned j = 0; j < 4; j++) begin
        sum[4*k+j] = bp[4*k+j] ^ c_run;
        c_run      = bg[4*k+j] | (bp[4*k+j] & c_run);
      end
    end
  end

  assign cout = gc[4];
  assign p    = &gp;
  assign g    = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0]);

endmodule

// File: rtl/seq_adder32.sv
// seq_adder32
//   Multi-cycle wide adder: one 16-bit CLA is reused over N_CHUNKS chunks,
//   least-significant chunk first, with the carry registered between chunks.
//   {cout, sum} = a + b + cin. Optional signed overflow flag when the macro
//   SEQ_ADDER_OVF_EN is defined.
// Parameters:
//   N_CHUNKS  : number of 16-bit chunks (2..8); operand width W = 16*N_CHUNKS
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   in_valid  : operands presented          in_ready  : idle, can accept
//   a, b, cin : operands and carry in
//   out_valid : result held                 out_ready : consumer takes result
//   sum, cout : registered result and carry out of the top chunk
//   ovf       : signed overflow (only with SEQ_ADDER_OVF_EN)
module seq_adder32
  import seq_adder32_pkg::*;
#(
  parameter int N_CHUNKS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHUNK_W*N_CHUNKS-1:0] a,
  input  logic [CHUNK_W*N_CHUNKS-1:0] b,
  input  logic                      cin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHUNK_W*N_CHUNKS-1:0] sum,
  output logic                      cout
`ifdef SEQ_ADDER_OVF_EN
  ,
  output logic                      ovf
`endif
);

  localparam int W     = CHUNK_W * N_CHUNKS;
  localparam int IDX_W = idx_width(N_CHUNKS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CHUNKS - 1);

  state_e             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
`ifdef SEQ_ADDER_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic [CHUNK_W-1:0] cla_a;
  logic [CHUNK_W-1:0] cla_b;
  logic [CHUNK_W-1:0] cla_sum;
  logic               cla_cout;
  logic               cla_p;
  logic               cla_g;
  logic               unused_pg;

  assign cla_a = a_q[CHUNK_W*idx_q +: CHUNK_W];
  assign cla_b = b_q[CHUNK_W*idx_q +: CHUNK_W];

  CLAAdder16 u_cla (
    .a    (cla_a),
    .b    (cla_b),
    .cin  (carry_q),
    .sum  (cla_sum),
    .cout (cla_cout),
    .p    (cla_p),
    .g    (cla_g)
  );

  assign unused_pg = cla_p ^ cla_g;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    idx_d       = idx_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef SEQ_ADDER_OVF_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b;
          carry_d    = cin;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[CHUNK_W*idx_q +: CHUNK_W] = cla_sum;
        carry_d = cla_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          cout_d      = cla_cout;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
`ifdef SEQ_ADDER_OVF_EN
          // Top-chunk sum MSB is still on the CLA output this cycle.
          ovf_d = (a_q[W-1] == b_q[W-1]) && (cla_sum[CHUNK_W-1] != a_q[W-1]);
`endif
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SEQ_ADDER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef SEQ_ADDER_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SEQ_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
